// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master, one-slave round-robin arbiter with a fixed-latency
// slave. Exactly one transaction is in flight at a time. The slave access
// lasts WAIT_CYC cycles, and the granted master then gets a one-cycle ack
// that carries the captured read data.
//
// Ports:
//   cpu_clk, cpu_rst            clock, synchronous active-high reset
//   m0_req/wen/addr/wdata       master 0 request (CPU data port)
//   m0_ack                      master 0 one-cycle completion pulse
//   m1_req/wen/addr/wdata       master 1 request (DMA / debug loader)
//   m1_ack                      master 1 one-cycle completion pulse
//   m_rdata                     captured read data, valid in the ack cycle
//   s_en, s_wen, s_addr,
//   s_wdata, s_rdata            slave (bridge Bus_*) access port
//   busy                        high while in ACCESS or DONE
//   grant_id                    master currently or last granted
module bus_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              m0_req,
  input  logic              m0_wen,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_wen,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m_rdata,
  output logic              s_en,
  output logic              s_wen,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              busy,
  output logic              grant_id
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             last_served;
  // s_wen only strobes in the first ACCESS cycle, so the read/write
  // direction of the transaction is kept separately for the capture decision.
  logic             xfer_wen;

  logic             any_req_c;
  logic             pick_m1_c;

  // On a tie, the master that was not served last wins.
  assign any_req_c = m0_req | m1_req;
  assign pick_m1_c = m1_req & (~m0_req | ~last_served);

  // Arbitration FSM; every output is a register.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      last_served <= 1'b1;
      xfer_wen    <= 1'b0;
      grant_id    <= 1'b0;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      m_rdata     <= '0;
      s_en        <= 1'b0;
      s_wen       <= 1'b0;
      s_addr      <= '0;
      s_wdata     <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          if (any_req_c) begin
            grant_id <= pick_m1_c;
            s_addr   <= pick_m1_c ? m1_addr  : m0_addr;
            s_wdata  <= pick_m1_c ? m1_wdata : m0_wdata;
            s_wen    <= pick_m1_c ? m1_wen   : m0_wen;
            xfer_wen <= pick_m1_c ? m1_wen   : m0_wen;
            s_en     <= 1'b1;
            busy     <= 1'b1;
            wait_cnt <= '0;
            state    <= ACCESS;
          end
        end

        ACCESS: begin
          // Single write strobe: s_wen drops after the first ACCESS cycle.
          s_wen    <= 1'b0;
          wait_cnt <= wait_cnt + CNT_W'(1);
          if (wait_cnt == LAST_CNT) begin
            if (!xfer_wen) begin
              m_rdata <= s_rdata;
            end
            s_en   <= 1'b0;
            m0_ack <= ~grant_id;
            m1_ack <= grant_id;
            state  <= DONE;
          end
        end

        DONE: begin
          m0_ack      <= 1'b0;
          m1_ack      <= 1'b0;
          busy        <= 1'b0;
          last_served <= grant_id;
          state       <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
